pong_frame_sequencer: RTL and testbench
=======================================

# pong_frame_sequencer

Once per video frame, sequences the Pong game-state update that feeds the VGA pixel datapath. It detects the frame boundary from the VGA driver's active-low vertical sync, then steps a fixed four-phase update: paddles, ball motion, collision, scoring. Outputs are object positions and scores, which the sprite/RGB mux uses to build the driver's `RGB_in`. Outputs change only inside vertical sync, so they are stable for the whole visible frame.

## Interface
Parameters:
- `SCREEN_W`, 640: visible width in pixels.
- `SCREEN_H`, 480: visible height in lines.
- `BALL_SIZE`, 8: ball edge length in pixels.
- `PADDLE_W`, 8: paddle width in pixels.
- `PADDLE_H`, 64: paddle height in pixels.
- `PADDLE_STEP`, 4: paddle move per update, in pixels.
- `BALL_STEP`, 2: ball move per axis per update, in pixels.
- `LEFT_X`, 16: left paddle left edge.
- `RIGHT_X`, 616: right paddle left edge.
- `FRAME_DIV`, 1: update every `FRAME_DIV` frames; must be ≥1.

Ports:
- `CLK_IN`  in  1: system clock (50 MHz), same clock that drives the VGA driver.
- `RST_IN`  in  1: reset, synchronous, active-high.
- `V_SYNC`  in  1: active-low vertical sync from the VGA driver; synchronous to `CLK_IN`, no synchroniser.
- `BTN_L_UP`, `BTN_L_DN`, `BTN_R_UP`, `BTN_R_DN`  in  1 each: debounced, level-sensitive paddle controls.
- `BALL_X`, `BALL_Y`  out  10 each: ball top-left corner in screen coordinates.
- `PAD_L_Y`, `PAD_R_Y`  out  10 each: paddle top edges.
- `SCORE_L`, `SCORE_R`  out  4 each: BCD digits, 0–9.
- `FRAME_TICK`  out  1: one-cycle pulse per detected frame start.
- `BUSY`  out  1: high while the update FSM is not in IDLE.

## Operation
Reset values:
- `BALL_X` = 316, `BALL_Y` = 236, i.e. `SCREEN_W/2 - BALL_SIZE/2` and `SCREEN_H/2 - BALL_SIZE/2`.
- `PAD_L_Y` = `PAD_R_Y` = 208, i.e. `(SCREEN_H - PADDLE_H)/2`.
- Scores 0; `FRAME_TICK` 0; `BUSY` 0; state IDLE; frame divider 0.
- Internal direction `dir_x` = right, `dir_y` = down.
- Sync history register = 1, so no false edge is seen out of reset.

Frame detect:
- `vs_q` is a registered copy of `V_SYNC`.
- A frame starts when `vs_q`=1 and `V_SYNC`=0; `FRAME_TICK` is registered and asserts on the next cycle.
- The divider counts ticks 0..`FRAME_DIV`-1. The update starts on the tick where the divider is 0.

FSM states and transitions: IDLE → PADDLES → BALL → COLLIDE → SCORE → IDLE, one cycle each.
- IDLE: leave on a `FRAME_TICK` cycle when the divider is 0.
- A tick arriving while `BUSY`=1 is ignored and does not advance the divider.

PADDLES, per paddle:
- up only: `y = (y < PADDLE_STEP) ? 0 : y - PADDLE_STEP`.
- down only: `y = min(y + PADDLE_STEP, SCREEN_H - PADDLE_H)`.
- both or neither: hold.

BALL:
- Add or subtract `BALL_STEP` per axis according to direction.
- Use 11-bit intermediates; clamp x to [0, `SCREEN_W - BALL_SIZE`] and y to [0, `SCREEN_H - BALL_SIZE`].

COLLIDE, using the values updated this frame:
- Vertical: `y`=0 → `dir_y`=down; `y`=`SCREEN_H - BALL_SIZE` → `dir_y`=up.
- Overlap with a paddle means `BALL_Y + BALL_SIZE > pad_y` and `BALL_Y < pad_y + PADDLE_H`.
- Left paddle: `dir_x`=left, `x ≤ LEFT_X + PADDLE_W`, and overlap → `dir_x`=right, `x = LEFT_X + PADDLE_W`.
- Right paddle: `dir_x`=right, `x + BALL_SIZE ≥ RIGHT_X`, and overlap → `dir_x`=left, `x = RIGHT_X - BALL_SIZE`.
- Corner case: vertical and paddle bounces may both apply in the same cycle.

SCORE:
- `x`=0 → `SCORE_R`++.
- `x`=`SCREEN_W - BALL_SIZE` → `SCORE_L`++.
- Score wraps 9→0.
- On a point, the ball returns to centre, `dir_x` inverts and `dir_y` is kept.
- No point → no change.

## Timing
- Update latency: `V_SYNC` falling edge seen at cycle n; `FRAME_TICK` high at n+1; `BUSY` high from n+2 to n+5.
- Final output values are visible at n+6; `BUSY` is 0 at n+6.
- Intermediate output values between n+3 and n+5 are legal, because they fall inside vertical sync.
- Buttons are sampled only in the PADDLES cycle.
- `RST_IN` mid-update: the next edge forces all reset values and IDLE; the frame in progress is abandoned.
- `RST_IN` has priority over frame detect in the same cycle.

## Test plan
- Reset, then hold `V_SYNC` at 1 for 1000 cycles → all reset values; `FRAME_TICK` never pulses.
- One `V_SYNC` 1→0 edge, no buttons → `FRAME_TICK` one cycle; `BUSY` 4 cycles; ball moves to (318, 238).
- `BTN_L_UP` held for 60 frames from `PAD_L_Y`=208 → `PAD_L_Y` reaches 0 after 52 updates and stays 0.
- Ball at x=24, y=240, moving left, `PAD_L_Y`=208 → after one update `dir_x` is right and `BALL_X`=24.
- Same as the previous case but `PAD_L_Y`=0 → ball reaches x=0; `SCORE_R` 0→1; ball returns to (316, 236).
- `SCORE_L` at 9 with ball reaching the right wall → `SCORE_L`=0.
- `FRAME_DIV`=3 → an update occurs only on the 1st, 4th and 7th ticks.
- `RST_IN` asserted in the BALL cycle → reset values on the next cycle.

Source files
------------

// File: rtl/pong_frame_sequencer.sv
// Pong game-state sequencer: on each V_SYNC fall, runs paddles -> ball -> collide -> score.
// Latency: FRAME_TICK 1 cycle after the edge is seen, BUSY for the next 4, final values 6 cycles after the edge.
// Backpressure: none; a frame tick that lands while BUSY is dropped and does not advance the divider.
module pong_frame_sequencer #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int BALL_SIZE   = 8,
    parameter int PADDLE_W    = 8,
    parameter int PADDLE_H    = 64,
    parameter int PADDLE_STEP = 4,
    parameter int BALL_STEP   = 2,
    parameter int LEFT_X      = 16,
    parameter int RIGHT_X     = 616,
    parameter int FRAME_DIV   = 1
) (
    input  logic       CLK_IN,
    input  logic       RST_IN,
    input  logic       V_SYNC,
    input  logic       BTN_L_UP,
    input  logic       BTN_L_DN,
    input  logic       BTN_R_UP,
    input  logic       BTN_R_DN,
    output logic [9:0] BALL_X,
    output logic [9:0] BALL_Y,
    output logic [9:0] PAD_L_Y,
    output logic [9:0] PAD_R_Y,
    output logic [3:0] SCORE_L,
    output logic [3:0] SCORE_R,
    output logic       FRAME_TICK,
    output logic       BUSY
);

    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(FRAME_DIV - 1);

    localparam logic [10:0] X_MAX   = 11'(SCREEN_W - BALL_SIZE);
    localparam logic [10:0] Y_MAX   = 11'(SCREEN_H - BALL_SIZE);
    localparam logic [10:0] PAD_MAX = 11'(SCREEN_H - PADDLE_H);
    localparam logic [10:0] X_CTR   = 11'(SCREEN_W / 2 - BALL_SIZE / 2);
    localparam logic [10:0] Y_CTR   = 11'(SCREEN_H / 2 - BALL_SIZE / 2);
    localparam logic [10:0] PAD_CTR = 11'((SCREEN_H - PADDLE_H) / 2);
    localparam logic [10:0] P_STEP  = 11'(PADDLE_STEP);
    localparam logic [10:0] B_STEP  = 11'(BALL_STEP);
    localparam logic [10:0] B_SIZE  = 11'(BALL_SIZE);
    localparam logic [10:0] P_H     = 11'(PADDLE_H);
    localparam logic [10:0] L_HIT   = 11'(LEFT_X + PADDLE_W);
    localparam logic [10:0] R_EDGE  = 11'(RIGHT_X);
    localparam logic [10:0] R_HIT   = 11'(RIGHT_X - BALL_SIZE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PADDLES,
        ST_BALL,
        ST_COLLIDE,
        ST_SCORE
    } state_t;

    state_t           state;
    logic             vs_q;
    logic             dir_x;   // 1 = right
    logic             dir_y;   // 1 = down
    logic [DIV_W-1:0] div_cnt;

    function automatic logic [9:0] pad_step(input logic [9:0] y, input logic up, input logic dn);
        logic [10:0] p;
        p = {1'b0, y};
        if (up && !dn)
            return (p < P_STEP) ? 10'd0 : 10'(p - P_STEP);
        if (dn && !up)
            return (p + P_STEP > PAD_MAX) ? PAD_MAX[9:0] : 10'(p + P_STEP);
        return y;
    endfunction

    // Clamped in 11 bits so a step past either wall lands exactly on it.
    function automatic logic [9:0] axis_step(input logic [9:0] pos, input logic inc,
                                             input logic [10:0] lim);
        logic [10:0] p;
        p = {1'b0, pos};
        if (inc)
            return (p + B_STEP > lim) ? lim[9:0] : 10'(p + B_STEP);
        return (p < B_STEP) ? 10'd0 : 10'(p - B_STEP);
    endfunction

    function automatic logic overlap(input logic [9:0] by, input logic [9:0] py);
        return ({1'b0, by} + B_SIZE > {1'b0, py}) && ({1'b0, by} < {1'b0, py} + P_H);
    endfunction

    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            state      <= ST_IDLE;
            vs_q       <= 1'b1;
            FRAME_TICK <= 1'b0;
            BUSY       <= 1'b0;
            div_cnt    <= '0;
            dir_x      <= 1'b1;
            dir_y      <= 1'b1;
            BALL_X     <= X_CTR[9:0];
            BALL_Y     <= Y_CTR[9:0];
            PAD_L_Y    <= PAD_CTR[9:0];
            PAD_R_Y    <= PAD_CTR[9:0];
            SCORE_L    <= 4'd0;
            SCORE_R    <= 4'd0;
        end else begin
            vs_q       <= V_SYNC;
            FRAME_TICK <= vs_q & ~V_SYNC;
            case (state)
                ST_IDLE: begin
                    if (FRAME_TICK) begin
                        div_cnt <= (div_cnt == DIV_MAX) ? '0 : div_cnt + 1'b1;
                        if (div_cnt == '0) begin
                            state <= ST_PADDLES;
                            BUSY  <= 1'b1;
                        end
                    end
                end
                ST_PADDLES: begin
                    PAD_L_Y <= pad_step(PAD_L_Y, BTN_L_UP, BTN_L_DN);
                    PAD_R_Y <= pad_step(PAD_R_Y, BTN_R_UP, BTN_R_DN);
                    state   <= ST_BALL;
                end
                ST_BALL: begin
                    BALL_X <= axis_step(BALL_X, dir_x, X_MAX);
                    BALL_Y <= axis_step(BALL_Y, dir_y, Y_MAX);
                    state  <= ST_COLLIDE;
                end
                ST_COLLIDE: begin
                    if (BALL_Y == 10'd0)
                        dir_y <= 1'b1;
                    else if (BALL_Y == Y_MAX[9:0])
                        dir_y <= 1'b0;
                    if (!dir_x && {1'b0, BALL_X} <= L_HIT && overlap(BALL_Y, PAD_L_Y)) begin
                        dir_x  <= 1'b1;
                        BALL_X <= L_HIT[9:0];
                    end else if (dir_x && {1'b0, BALL_X} + B_SIZE >= R_EDGE
                                 && overlap(BALL_Y, PAD_R_Y)) begin
                        dir_x  <= 1'b0;
                        BALL_X <= R_HIT[9:0];
                    end
                    state <= ST_SCORE;
                end
                ST_SCORE: begin
                    if (BALL_X == 10'd0) begin
                        SCORE_R <= (SCORE_R == 4'd9) ? 4'd0 : SCORE_R + 4'd1;
                        BALL_X  <= X_CTR[9:0];
                        BALL_Y  <= Y_CTR[9:0];
                        dir_x   <= ~dir_x;
                    end else if (BALL_X == X_MAX[9:0]) begin
                        SCORE_L <= (SCORE_L == 4'd9) ? 4'd0 : SCORE_L + 4'd1;
                        BALL_X  <= X_CTR[9:0];
                        BALL_Y  <= Y_CTR[9:0];
                        dir_x   <= ~dir_x;
                    end
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_frame_sequencer.sv
// Scoreboard bench for pong_frame_sequencer: random frames against a behavioural game model, two divider settings.
module tb_pong_frame_sequencer;

    localparam int W = 640, H = 480, BS = 8, PW = 8, PH = 64;
    localparam int PSTEP = 4, BSTEP = 2, LX = 16, RX = 616;
    localparam int XMAX = W - BS, YMAX = H - BS, PMAX = H - PH;
    localparam int XC = W / 2 - BS / 2, YC = H / 2 - BS / 2, PC = (H - PH) / 2;

    typedef struct {
        int bx, by, pl, pr, sl, sr, dx, dy;
    } gs_t;

    logic       clk;
    logic       rst, v_sync, l_up, l_dn, r_up, r_dn;
    logic [9:0] bx1, by1, pl1, pr1, bx3, by3, pl3, pr3;
    logic [3:0] sl1, sr1, sl3, sr3;
    logic       tick1, busy1, tick3, busy3;

    int   vectors = 0, miscompares = 0;
    gs_t  m1, m3, e1, e3;
    gs_t  exp1[$], exp3[$];
    int   acc3 = 0, exp_ticks = 0, tick_cnt1 = 0, upd3 = 0;
    int   busy_run1 = 0, busy_run3 = 0, tick_run1 = 0;
    logic busy1_q = 0, busy3_q = 0, tick1_q = 0, tick3_q = 0, rst_q = 0;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    pong_frame_sequencer dut1 (
        .CLK_IN(clk), .RST_IN(rst), .V_SYNC(v_sync),
        .BTN_L_UP(l_up), .BTN_L_DN(l_dn), .BTN_R_UP(r_up), .BTN_R_DN(r_dn),
        .BALL_X(bx1), .BALL_Y(by1), .PAD_L_Y(pl1), .PAD_R_Y(pr1),
        .SCORE_L(sl1), .SCORE_R(sr1), .FRAME_TICK(tick1), .BUSY(busy1)
    );

    pong_frame_sequencer #(.FRAME_DIV(3)) dut3 (
        .CLK_IN(clk), .RST_IN(rst), .V_SYNC(v_sync),
        .BTN_L_UP(l_up), .BTN_L_DN(l_dn), .BTN_R_UP(r_up), .BTN_R_DN(r_dn),
        .BALL_X(bx3), .BALL_Y(by3), .PAD_L_Y(pl3), .PAD_R_Y(pr3),
        .SCORE_L(sl3), .SCORE_R(sr3), .FRAME_TICK(tick3), .BUSY(busy3)
    );

    // ---------------- reference model ----------------
    function automatic gs_t init_state();
        gs_t s;
        s.bx = XC; s.by = YC; s.pl = PC; s.pr = PC;
        s.sl = 0;  s.sr = 0;  s.dx = 1;  s.dy = 1;
        return s;
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic bit hits(input int by, input int py);
        return (by + BS > py) && (by < py + PH);
    endfunction

    function automatic int move_pad(input int y, input bit up, input bit dn);
        if (up && !dn) return clampi(y - PSTEP, 0, PMAX);
        if (dn && !up) return clampi(y + PSTEP, 0, PMAX);
        return y;
    endfunction

    function automatic gs_t step(input gs_t s, input bit lu, input bit ld, input bit ru, input bit rd);
        gs_t n;
        n = s;
        n.pl = move_pad(n.pl, lu, ld);
        n.pr = move_pad(n.pr, ru, rd);
        n.bx = clampi(n.bx + BSTEP * n.dx, 0, XMAX);
        n.by = clampi(n.by + BSTEP * n.dy, 0, YMAX);
        if (n.by == 0)    n.dy = 1;
        if (n.by == YMAX) n.dy = -1;
        if (n.dx < 0 && n.bx <= LX + PW && hits(n.by, n.pl)) begin
            n.dx = 1;  n.bx = LX + PW;
        end else if (n.dx > 0 && n.bx + BS >= RX && hits(n.by, n.pr)) begin
            n.dx = -1; n.bx = RX - BS;
        end
        if (n.bx == 0 || n.bx == XMAX) begin
            if (n.bx == 0) n.sr = (n.sr + 1) % 10;
            else           n.sl = (n.sl + 1) % 10;
            n.bx = XC; n.by = YC; n.dx = -n.dx;
        end
        return n;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic cmp_state(input string nm, input gs_t e, input int bx, input int by,
                             input int pl, input int pr, input int sl, input int sr);
        vectors++;
        if (bx !== e.bx || by !== e.by || pl !== e.pl || pr !== e.pr || sl !== e.sl || sr !== e.sr) begin
            miscompares++;
            $display("FAIL %s: got ball(%0d,%0d) pads(%0d,%0d) score(%0d,%0d), expected ball(%0d,%0d) pads(%0d,%0d) score(%0d,%0d)",
                     nm, bx, by, pl, pr, sl, sr, e.bx, e.by, e.pl, e.pr, e.sl, e.sr);
        end
    endtask

    always @(negedge clk) begin
        // FRAME_TICK pulse count and width (divider-1 instance)
        if (tick1) begin
            if (!tick1_q) tick_cnt1++;
            tick_run1++;
        end else if (tick1_q) begin
            chk("tick_width", tick_run1, 1);
            tick_run1 = 0;
        end
        if (busy1 && !busy1_q) chk("busy1_follows_tick", int'(tick1_q), 1);
        if (busy3 && !busy3_q) chk("busy3_follows_tick", int'(tick3_q), 1);
        if (busy1) busy_run1++;
        if (busy3) busy_run3++;
        if (!busy1 && busy1_q) begin
            if (!rst_q) begin
                chk("busy1_len", busy_run1, 4);
                if (exp1.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL upd1: update seen with no expected result");
                end else begin
                    e1 = exp1.pop_front();
                    cmp_state("upd1", e1, int'(bx1), int'(by1), int'(pl1), int'(pr1), int'(sl1), int'(sr1));
                end
            end
            busy_run1 = 0;
        end
        if (!busy3 && busy3_q) begin
            if (!rst_q) begin
                chk("busy3_len", busy_run3, 4);
                upd3++;
                if (exp3.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL upd3: update seen with no expected result");
                end else begin
                    e3 = exp3.pop_front();
                    cmp_state("upd3", e3, int'(bx3), int'(by3), int'(pl3), int'(pr3), int'(sl3), int'(sr3));
                end
            end
            busy_run3 = 0;
        end
        busy1_q = busy1; busy3_q = busy3;
        tick1_q = tick1; tick3_q = tick3;
        rst_q   = rst;
    end

    // ---------------- stimulus ----------------
    task automatic model_reset();
        m1 = init_state(); m3 = init_state(); acc3 = 0;
    endtask

    task automatic tick3_accept(input bit lu, input bit ld, input bit ru, input bit rd, output bit started);
        started = (acc3 % 3 == 0);
        if (started) begin
            m3 = step(m3, lu, ld, ru, rd);
            exp3.push_back(m3);
        end
        acc3++;
    endtask

    // dbl issues a second V_SYNC edge while the first update is still running.
    task automatic do_frame(input bit lu, input bit ld, input bit ru, input bit rd, input bit dbl);
        bit st3, dummy;
        @(posedge clk); #1;
        {l_up, l_dn, r_up, r_dn} = {lu, ld, ru, rd};
        v_sync = 1'b0;
        exp_ticks++;
        m1 = step(m1, lu, ld, ru, rd);
        exp1.push_back(m1);
        tick3_accept(lu, ld, ru, rd, st3);
        @(posedge clk); #1 v_sync = 1'b1;
        if (dbl) begin
            @(posedge clk); #1 v_sync = 1'b0;
            exp_ticks++;
            if (!st3) tick3_accept(lu, ld, ru, rd, dummy);
            @(posedge clk); #1 v_sync = 1'b1;
        end
        repeat (6) @(posedge clk);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ball_x"}, int'(bx1), 316);
        chk({tag, "_ball_y"}, int'(by1), 236);
        chk({tag, "_pad_l"},  int'(pl1), 208);
        chk({tag, "_pad_r"},  int'(pr1), 208);
        chk({tag, "_scores"}, int'({sl1, sr1}), 0);
        chk({tag, "_busy"},   int'(busy1), 0);
        chk({tag, "_tick"},   int'(tick1), 0);
        chk({tag, "_ball_x3"}, int'(bx3), 316);
    endtask

    initial begin
        rst = 1'b1; v_sync = 1'b1;
        {l_up, l_dn, r_up, r_dn} = 4'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // idle with V_SYNC high: nothing moves, no tick
        repeat (1000) @(posedge clk);
        @(negedge clk);
        chk_reset_values("idle");
        chk("idle_no_tick", tick_cnt1, 0);

        // first frame, no buttons
        do_frame(0, 0, 0, 0, 0);
        chk("frame1_ball_x", int'(bx1), 318);
        chk("frame1_ball_y", int'(by1), 238);
        chk("frame1_ticks", tick_cnt1, 1);
        chk("frame1_div3_ball_x", int'(bx3), 318);

        // left paddle up for 60 frames: 52 steps reach the top and stay there
        for (int i = 0; i < 60; i++) begin
            do_frame(1, 0, 0, 0, 0);
            if (i == 5)  chk("div3_updates_after_7_ticks", upd3, 3);
            if (i == 50) chk("pad_l_after_51", int'(pl1), 4);
            if (i == 51) chk("pad_l_after_52", int'(pl1), 0);
        end
        chk("pad_l_after_60", int'(pl1), 0);

        // paddles mostly parked at the top: many points, exercising score wrap
        for (int i = 0; i < 4000; i++)
            do_frame($urandom_range(9) != 0, $urandom_range(9) == 0,
                     $urandom_range(9) != 0, $urandom_range(9) == 0, $urandom_range(9) == 0);

        // free random play: bounces off paddles and walls
        for (int i = 0; i < 2000; i++)
            do_frame($urandom_range(2) == 0, $urandom_range(2) == 0,
                     $urandom_range(2) == 0, $urandom_range(2) == 0, $urandom_range(7) == 0);

        chk("q1_drained_before_reset", exp1.size(), 0);
        chk("q3_drained_before_reset", exp3.size(), 0);

        // reset during the BALL cycle abandons the update
        @(posedge clk); #1 v_sync = 1'b0; l_up = 1'b1; l_dn = 1'b0; r_up = 1'b0; r_dn = 1'b1;
        exp_ticks++;
        @(posedge clk); #1 v_sync = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        chk("busy_in_ball_cycle", int'(busy1), 1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_values("midrst");
        model_reset();
        repeat (4) @(posedge clk);

        for (int i = 0; i < 40; i++)
            do_frame($urandom_range(1), $urandom_range(1), $urandom_range(1), $urandom_range(1),
                     $urandom_range(4) == 0);

        repeat (10) @(posedge clk);
        chk("q1_drained", exp1.size(), 0);
        chk("q3_drained", exp3.size(), 0);
        chk("tick_count", tick_cnt1, exp_ticks);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
